// File: rtl/key_debounce_bank.sv
// Multi-channel push-button conditioner: per-key synchroniser, stable-count debounce,
// press/release pulses and long-press detection from one shared hold-tick prescaler.

module key_debounce_lane #(
   parameter int STABLE_CNT = 1000,
   parameter int ACTIVE_LOW = 1,
   parameter int LONG_TICKS = 1000,
   parameter int CNT_W      = 10,
   parameter int HOLD_W     = 10
) (
   input  logic clk50M,
   input  logic rst_,
   input  logic key_raw,
   input  logic tick,
   output logic key_pressed,
   output logic press_p,
   output logic release_p,
   output logic long_p,
   output logic long_held
);
   localparam logic              IDLE     = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CNT - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_TICKS - 1);

   logic              s1_q, s1_d, s2_q, s2_d, db_q, db_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              press_q, press_d, release_q, release_d;
   logic              long_q, long_d, held_q, held_d;
   logic              accept, pressed_now;

   assign pressed_now = (db_q != IDLE);

   always_comb begin
      s1_d      = key_raw;
      s2_d      = s1_q;
      db_d      = db_q;
      cnt_d     = '0;
      hold_d    = hold_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      held_d    = held_q;
      accept    = 1'b0;
      // any cycle where the synchronised level matches db restarts the count
      if (s2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d   = s2_q;
            accept = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (accept) begin
         hold_d = '0;
         if (pressed_now) begin
            release_d = 1'b1;
            held_d    = 1'b0;
         end else begin
            press_d = 1'b1;
         end
      end else if (!pressed_now) begin
         hold_d = '0;
      end else if (tick && (hold_q != HOLD_MAX)) begin
         hold_d = hold_q + 1'b1;
         if (hold_q == HOLD_PRE) begin
            long_d = 1'b1;
            held_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk50M or negedge rst_) begin
      if (!rst_) begin
         s1_q      <= IDLE;
         s2_q      <= IDLE;
         db_q      <= IDLE;
         cnt_q     <= '0;
         hold_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         db_q      <= db_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         held_q    <= held_d;
      end
   end

   assign key_pressed = pressed_now;
   assign press_p     = press_q;
   assign release_p   = release_q;
   assign long_p      = long_q;
   assign long_held   = held_q;
endmodule

module key_debounce_bank #(
   parameter int N_KEYS     = 4,
   parameter int STABLE_CNT = 1000,
   parameter int ACTIVE_LOW = 1,
   parameter int TICK_DIV   = 50000,
   parameter int LONG_TICKS = 1000
) (
   input  logic              clk50M,
   input  logic              rst_,
   input  logic [N_KEYS-1:0] KEY,
   output logic [N_KEYS-1:0] key_pressed,
   output logic [N_KEYS-1:0] press_p,
   output logic [N_KEYS-1:0] release_p,
   output logic [N_KEYS-1:0] long_p,
   output logic [N_KEYS-1:0] long_held
);
   localparam int CNT_W  = $clog2(STABLE_CNT + 1);
   localparam int TDIV_W = $clog2(TICK_DIV);
   localparam int HOLD_W = $clog2(LONG_TICKS + 1);
   localparam logic [TDIV_W-1:0] TDIV_LAST = TDIV_W'(TICK_DIV - 1);

   logic [TDIV_W-1:0] tdiv_q, tdiv_d;
   logic              tick;

   assign tick = (tdiv_q == TDIV_LAST);

   always_comb begin
      tdiv_d = tick ? '0 : tdiv_q + 1'b1;
   end

   always_ff @(posedge clk50M or negedge rst_) begin
      if (!rst_) tdiv_q <= '0;
      else       tdiv_q <= tdiv_d;
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
      key_debounce_lane #(
         .STABLE_CNT (STABLE_CNT),
         .ACTIVE_LOW (ACTIVE_LOW),
         .LONG_TICKS (LONG_TICKS),
         .CNT_W      (CNT_W),
         .HOLD_W     (HOLD_W)
      ) u_lane (
         .clk50M      (clk50M),
         .rst_        (rst_),
         .key_raw     (KEY[i]),
         .tick        (tick),
         .key_pressed (key_pressed[i]),
         .press_p     (press_p[i]),
         .release_p   (release_p[i]),
         .long_p      (long_p[i]),
         .long_held   (long_held[i])
      );
   end
endmodule

// File: tb/tb_key_debounce_bank.sv
// Directed bench for key_debounce_bank: N_KEYS=2, STABLE_CNT=8, active-low, TICK_DIV=4, LONG_TICKS=3.

module tb_key_debounce_bank;
   logic       clk50M = 1'b0;
   logic       rst_   = 1'b0;
   logic [1:0] KEY    = 2'b11;
   logic [1:0] key_pressed, press_p, release_p, long_p, long_held;
   int         checks = 0;
   int         errors = 0;

   key_debounce_bank #(
      .N_KEYS(2), .STABLE_CNT(8), .ACTIVE_LOW(1), .TICK_DIV(4), .LONG_TICKS(3)
   ) dut (
      .clk50M(clk50M), .rst_(rst_), .KEY(KEY), .key_pressed(key_pressed),
      .press_p(press_p), .release_p(release_p), .long_p(long_p), .long_held(long_held)
   );

   always #5 clk50M = ~clk50M;

   task automatic edge1();
      @(posedge clk50M);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({key_pressed, press_p, release_p, long_p, long_held} !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0", {key_pressed, press_p, release_p, long_p, long_held});
      end
      @(negedge clk50M);
      rst_ = 1'b1;
      begin
         bit bad = 0;
         for (int i = 0; i < 100; i++) begin
            edge1();
            if ({key_pressed, press_p, release_p, long_p, long_held} !== 10'b0) bad = 1;
         end
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL idle_quiet got activity want all 0 for 100 cycles");
         end
      end
   endtask

   task automatic test_press();
      bit early = 0;
      @(negedge clk50M);
      KEY = 2'b10;
      for (int i = 0; i <= 8; i++) begin
         edge1();
         if (press_p !== 2'b00 || key_pressed !== 2'b00) early = 1;
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL press_early got press before edge k+9 want none");
      end
      edge1();
      checks++;
      if (press_p !== 2'b01 || key_pressed !== 2'b01) begin
         errors++;
         $display("FAIL press_latency got press_p=%b key_pressed=%b want 01/01", press_p, key_pressed);
      end
   endtask

   task automatic test_long();
      int first = -1;
      int cnt = 0;
      bit held_bad = 0;
      bit press_again = 0;
      for (int n = 1; n <= 40; n++) begin
         edge1();
         if (press_p !== 2'b00) press_again = 1;
         if (long_p[0]) begin
            cnt++;
            if (first < 0) first = n;
         end
         if (first < 0 && long_held[0]) held_bad = 1;
         if (first >= 0 && !long_held[0]) held_bad = 1;
      end
      checks++;
      if (press_again) begin
         errors++;
         $display("FAIL press_single got repeated press_p want one pulse");
      end
      checks++;
      if (first < 9 || first > 12) begin
         errors++;
         $display("FAIL long_timing got %0d cycles after press want 9..12", first);
      end
      checks++;
      if (cnt != 1) begin
         errors++;
         $display("FAIL long_count got %0d want 1", cnt);
      end
      checks++;
      if (held_bad) begin
         errors++;
         $display("FAIL long_held_level got wrong level around long_p want 0 before, 1 after");
      end
   endtask

   task automatic test_release();
      bit early = 0;
      bit extra = 0;
      @(negedge clk50M);
      KEY = 2'b11;
      for (int i = 0; i <= 8; i++) begin
         edge1();
         if (release_p !== 2'b00 || long_held[0] !== 1'b1) early = 1;
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL release_early got release/long_held change before k+9 want none");
      end
      edge1();
      checks++;
      if (release_p !== 2'b01 || long_held !== 2'b00 || key_pressed !== 2'b00 || press_p !== 2'b00) begin
         errors++;
         $display("FAIL release_edge got rel=%b held=%b kp=%b pp=%b want 01/00/00/00",
                  release_p, long_held, key_pressed, press_p);
      end
      for (int i = 0; i < 20; i++) begin
         edge1();
         if ({press_p, release_p, long_p, long_held} !== 8'b0) extra = 1;
      end
      checks++;
      if (extra) begin
         errors++;
         $display("FAIL after_release got pulses/long after release want none");
      end
   endtask

   task automatic test_bounce();
      bit bad = 0;
      for (int r = 0; r < 4; r++) begin
         @(negedge clk50M);
         KEY = 2'b10;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk50M);
            if (press_p !== 2'b00 || key_pressed !== 2'b00) bad = 1;
         end
         KEY = 2'b11;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk50M);
            if (press_p !== 2'b00 || key_pressed !== 2'b00) bad = 1;
         end
      end
      for (int i = 0; i < 15; i++) begin
         edge1();
         if (press_p !== 2'b00 || key_pressed !== 2'b00) bad = 1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL bounce got press accepted want rejected");
      end
   endtask

   task automatic test_simultaneous();
      bit early = 0;
      bit after = 0;
      @(negedge clk50M);
      KEY = 2'b01;
      for (int i = 0; i < 12; i++) edge1();
      checks++;
      if (key_pressed !== 2'b10) begin
         errors++;
         $display("FAIL key1_press got %b want 10", key_pressed);
      end
      @(negedge clk50M);
      KEY = 2'b10;
      for (int i = 0; i <= 8; i++) begin
         edge1();
         if (press_p !== 2'b00 || release_p !== 2'b00) early = 1;
      end
      edge1();
      checks++;
      if (early || press_p !== 2'b01 || release_p !== 2'b10 || key_pressed !== 2'b01) begin
         errors++;
         $display("FAIL simultaneous got pp=%b rp=%b kp=%b early=%0d want 01/10/01/0",
                  press_p, release_p, key_pressed, early);
      end
      for (int i = 0; i < 5; i++) edge1();
      #2;
      rst_ = 1'b0;
      #1;
      checks++;
      if ({key_pressed, press_p, release_p, long_p, long_held} !== 10'b0) begin
         errors++;
         $display("FAIL async_reset got %b want 0", {key_pressed, press_p, release_p, long_p, long_held});
      end
      KEY = 2'b11;
      repeat (3) @(negedge clk50M);
      rst_ = 1'b1;
      for (int i = 0; i < 30; i++) begin
         edge1();
         if ({key_pressed, press_p, release_p, long_p, long_held} !== 10'b0) after = 1;
      end
      checks++;
      if (after) begin
         errors++;
         $display("FAIL post_reset got activity (release after reset) want none");
      end
   endtask

   task automatic test_held_through_reset();
      bit early = 0;
      @(negedge clk50M);
      rst_ = 1'b0;
      KEY  = 2'b10;
      repeat (2) @(negedge clk50M);
      rst_ = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         edge1();
         if (press_p !== 2'b00) early = 1;
      end
      edge1();
      checks++;
      if (early || press_p !== 2'b01 || key_pressed !== 2'b01) begin
         errors++;
         $display("FAIL held_through_reset got pp=%b kp=%b early=%0d want 01/01/0", press_p, key_pressed, early);
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_long();
      test_release();
      test_bounce();
      test_simultaneous();
      test_held_through_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
